// File: rtl/mdu_pkg.sv
// Shared types and decode helpers for the multiply/divide unit.
package mdu_pkg;

  typedef enum logic [2:0] {
    OpMul    = 3'b000,
    OpMulh   = 3'b001,
    OpMulhsu = 3'b010,
    OpMulhu  = 3'b011,
    OpDiv    = 3'b100,
    OpDivu   = 3'b101,
    OpRem    = 3'b110,
    OpRemu   = 3'b111
  } mdu_op_e;

  typedef enum logic [1:0] {
    StIdle,
    StCalc,
    StFix
  } mdu_state_e;

  function automatic logic is_signed_div(mdu_op_e op);
    return (op == OpDiv) || (op == OpRem);
  endfunction

  function automatic logic is_signed_a(mdu_op_e op);
    return (op == OpMulh) || (op == OpMulhsu) || is_signed_div(op);
  endfunction

  function automatic logic is_signed_b(mdu_op_e op);
    return (op == OpMulh) || is_signed_div(op);
  endfunction

endpackage

// File: rtl/div_iter.sv
// One restoring-division step; in add mode the same adder serves a shift-add multiply step.
module div_iter #(
  parameter int unsigned XLEN = 32
) (
  input  logic            i_add,
  input  logic [XLEN-1:0] i_rem,
  input  logic            i_bit,
  input  logic [XLEN-1:0] i_divisor,
  output logic [XLEN-1:0] o_rem,
  output logic            o_qbit,
  output logic [XLEN:0]   o_sum
);

  logic [XLEN+1:0] w_a;
  logic [XLEN+1:0] w_b;
  logic [XLEN+1:0] w_sum;

  always_comb begin
    w_a    = i_add ? {2'b00, i_rem} : {1'b0, i_rem, i_bit};
    w_b    = i_add ? {2'b00, i_divisor} : ~{2'b00, i_divisor};
    w_sum  = w_a + w_b + {{(XLEN + 1){1'b0}}, ~i_add};
    // Sign of the trial difference: clear means the divisor fits.
    o_qbit = ~w_sum[XLEN+1];
    o_rem  = o_qbit ? w_sum[XLEN-1:0] : {i_rem[XLEN-2:0], i_bit};
    o_sum  = w_sum[XLEN:0];
  end

endmodule

// File: rtl/mul_div_unit.sv
// RISC-V M-extension multiply/divide unit: iterative divide, single-cycle or shift-add multiply.
module mul_div_unit
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN     = 32,
  parameter bit          FAST_MUL = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_start,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_src_a,
  input  logic [XLEN-1:0] i_src_b,
  input  logic            i_kill,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int unsigned CntW = $clog2(XLEN);

  mdu_state_e      r_state, w_state_nxt;
  mdu_op_e         r_op, w_op_nxt;
  logic [CntW-1:0] r_cnt, w_cnt_nxt;
  logic [XLEN-1:0] r_rem, w_rem_nxt;
  logic [XLEN-1:0] r_quo, w_quo_nxt;
  logic [XLEN-1:0] r_div, w_div_nxt;
  logic            r_neg_q, w_neg_q_nxt;
  logic            r_neg_r, w_neg_r_nxt;
  logic            r_done, w_done_nxt;
  logic [XLEN-1:0] r_result, w_result_nxt;

  mdu_op_e         w_op_in;
  logic            w_in_div;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic [2*XLEN-1:0] w_fast_prod;

  logic [XLEN-1:0]   w_step_divisor;
  logic [XLEN-1:0]   w_step_rem;
  logic              w_step_qbit;
  logic [XLEN:0]     w_step_sum;
  logic [2*XLEN-1:0] w_prod_fix;
  logic [XLEN-1:0]   w_quo_fix;
  logic [XLEN-1:0]   w_rem_fix;
  logic [XLEN-1:0]   w_fix_result;

  assign w_op_in  = mdu_op_e'(i_op);
  assign w_in_div = i_op[2];
  assign w_a_neg  = is_signed_a(w_op_in) & i_src_a[XLEN-1];
  assign w_b_neg  = is_signed_b(w_op_in) & i_src_b[XLEN-1];
  assign w_abs_a  = w_a_neg ? -i_src_a : i_src_a;
  assign w_abs_b  = w_b_neg ? -i_src_b : i_src_b;
  assign w_b_zero = (i_src_b == '0);
  assign w_ovf    = is_signed_div(w_op_in) && (i_src_a == {1'b1, {(XLEN - 1){1'b0}}}) &&
                    (&i_src_b);

  if (FAST_MUL) begin : g_fast_mul
    logic [2*XLEN-1:0] w_a_ext;
    logic [2*XLEN-1:0] w_b_ext;
    // Product modulo 2^(2*XLEN) of sign/zero-extended operands is the exact full product.
    assign w_a_ext     = {{XLEN{w_a_neg}}, i_src_a};
    assign w_b_ext     = {{XLEN{w_b_neg}}, i_src_b};
    assign w_fast_prod = w_a_ext * w_b_ext;
  end else begin : g_iter_mul
    assign w_fast_prod = '0;
  end

  // Multiply steps add the multiplicand only when the multiplier LSB is set.
  assign w_step_divisor = (r_op[2] || r_quo[0]) ? r_div : '0;

  div_iter #(
    .XLEN(XLEN)
  ) u_div_iter (
    .i_add    (~r_op[2]),
    .i_rem    (r_rem),
    .i_bit    (r_quo[XLEN-1]),
    .i_divisor(w_step_divisor),
    .o_rem    (w_step_rem),
    .o_qbit   (w_step_qbit),
    .o_sum    (w_step_sum)
  );

  assign w_prod_fix   = r_neg_q ? -{r_rem, r_quo} : {r_rem, r_quo};
  assign w_quo_fix    = r_neg_q ? -r_quo : r_quo;
  assign w_rem_fix    = r_neg_r ? -r_rem : r_rem;
  assign w_fix_result = r_op[2] ? (r_op[1] ? w_rem_fix : w_quo_fix) :
                        (r_op == OpMul) ? w_prod_fix[XLEN-1:0] : w_prod_fix[2*XLEN-1:XLEN];

  always_comb begin
    w_state_nxt  = r_state;
    w_op_nxt     = r_op;
    w_cnt_nxt    = r_cnt;
    w_rem_nxt    = r_rem;
    w_quo_nxt    = r_quo;
    w_div_nxt    = r_div;
    w_neg_q_nxt  = r_neg_q;
    w_neg_r_nxt  = r_neg_r;
    w_done_nxt   = 1'b0;
    w_result_nxt = r_result;

    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_op_nxt = w_op_in;
          if (!w_in_div && FAST_MUL) begin
            w_result_nxt = (w_op_in == OpMul) ? w_fast_prod[XLEN-1:0] :
                                                w_fast_prod[2*XLEN-1:XLEN];
            w_done_nxt   = 1'b1;
          end else if (w_in_div && w_b_zero) begin
            w_result_nxt = i_op[1] ? i_src_a : '1;
            w_done_nxt   = 1'b1;
          end else if (w_ovf) begin
            w_result_nxt = i_op[1] ? '0 : i_src_a;
            w_done_nxt   = 1'b1;
          end else begin
            w_state_nxt = StCalc;
            w_cnt_nxt   = CntW'(XLEN - 1);
            w_rem_nxt   = '0;
            w_quo_nxt   = w_in_div ? w_abs_a : w_abs_b;
            w_div_nxt   = w_in_div ? w_abs_b : w_abs_a;
            w_neg_q_nxt = w_a_neg ^ w_b_neg;
            w_neg_r_nxt = w_a_neg;
          end
        end
      end
      StCalc: begin
        if (r_op[2]) begin
          w_rem_nxt = w_step_rem;
          w_quo_nxt = {r_quo[XLEN-2:0], w_step_qbit};
        end else begin
          {w_rem_nxt, w_quo_nxt} = {w_step_sum, r_quo[XLEN-1:1]};
        end
        if (r_cnt == '0) begin
          w_state_nxt = StFix;
        end else begin
          w_cnt_nxt = r_cnt - 1'b1;
        end
      end
      StFix: begin
        w_result_nxt = w_fix_result;
        w_done_nxt   = 1'b1;
        w_state_nxt  = StIdle;
      end
      default: w_state_nxt = StIdle;
    endcase

    // A flush drops any request or operation and leaves the last result intact.
    if (i_kill) begin
      w_state_nxt  = StIdle;
      w_done_nxt   = 1'b0;
      w_result_nxt = r_result;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state  <= StIdle;
      r_op     <= OpMul;
      r_cnt    <= '0;
      r_rem    <= '0;
      r_quo    <= '0;
      r_div    <= '0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_op     <= w_op_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rem    <= w_rem_nxt;
      r_quo    <= w_quo_nxt;
      r_div    <= w_div_nxt;
      r_neg_q  <= w_neg_q_nxt;
      r_neg_r  <= w_neg_r_nxt;
      r_done   <= w_done_nxt;
      r_result <= w_result_nxt;
    end
  end

  assign o_busy   = (r_state != StIdle);
  assign o_done   = r_done;
  assign o_result = r_result;

endmodule
